sorted_drain: RTL and testbench
===============================

Name: sorted_drain

Overview:
- Batch sorter that sits downstream of the stream-statistics blocks.
- Captures a batch of up to DEPTH unsigned words from a valid/ready input stream.
- Replays the batch on a valid/ready output stream in descending order, largest first. This is the reader/emitter counterpart to the running-max trackers.
- Used to produce ranked results, for example the top-N, from a collected batch.

Parameters:
- DATA_WIDTH, 32, width of each data word; compared as unsigned.
- DEPTH, 8, maximum batch size in entries; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  din/in_last are valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- din  input  DATA_WIDTH  input data word.
- in_last  input  1  marks the final word of the batch; qualified by in_valid.
- out_valid  output  1  dout/out_last are valid this cycle.
- out_ready  input  1  downstream accepts dout this cycle.
- dout  output  DATA_WIDTH  current largest remaining entry.
- out_last  output  1  asserted with the final word of the drain.
- count  output  $clog2(DEPTH+1)  number of entries currently held.

Behaviour:
- Storage: DEPTH entries, each a DATA_WIDTH data word plus a used flag. A counter holds the number of used entries.
- States: FILL and DRAIN.
- Reset (async, resetn=0):
  - state=FILL; all used flags=0; count=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, dout=0.
  - Reset applied mid-fill or mid-drain discards the batch immediately; no partial output follows.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: write din into the lowest-index unused entry; count++.
  - Go to DRAIN on the next cycle if in_last=1 on the accepted beat, or if the accept makes count==DEPTH (implicit last).
  - in_last is ignored unless in_valid=1.
  - No empty batches exist: a batch always contains at least the beat carrying in_last.
- DRAIN:
  - in_ready=0, out_valid=1.
  - dout is the maximum over used entries, combinational from storage.
  - Ties: the lowest-index used entry is selected. Equal values are all emitted; duplicates are never merged.
  - out_last=1 iff count==1.
  - On out_valid&&out_ready: clear the selected entry's used flag; count--.
  - If count was 1, state returns to FILL the next cycle with in_ready=1.
  - out_ready=0 holds dout/out_last stable; no state change.
- Latency:
  - The first out_valid is the cycle after the final input beat is accepted.
  - One output word per cycle when out_ready is held high; a batch of N drains in exactly N cycles.
  - One idle cycle is allowed between batches (FILL re-entry); no overlap of fill and drain.
- Width rules:
  - count never exceeds DEPTH and never underflows.
  - Comparison is full-width unsigned; 0 and {DATA_WIDTH{1'b1}} are valid data values.
- Outside DRAIN, dout is 0.

Test Plan:
- Basic sort: DEPTH=8; push 5,9,2,7 with in_last on 7 -> cycle after: out_valid=1, dout=9; with out_ready=1, output sequence 9,7,5,2; out_last only on 2; in_ready=1 the following cycle.
- Auto-full: push 8 words 1..8 with no in_last -> in_ready drops after the 8th accept; drain 8,7,...,1; count goes 8→0.
- Duplicates and extremes: push 3,0xFFFFFFFF,3,0 (last) -> output 0xFFFFFFFF,3,3,0; four beats exactly.
- Backpressure: batch 4,6 (last); out_ready=0 for 5 cycles -> dout=6 held, out_last=0, count=2; then out_ready=1 -> 6, then 4 with out_last=1.
- Single-entry batch: push 42 with in_last -> one beat dout=42, out_last=1 -> back to FILL.
- Reset mid-drain: batch 10,20,30; after 20 is popped, pulse resetn low -> immediately out_valid=0, count=0, in_ready=1; a new batch 1 (last) drains only 1.

Source files
------------

// File: rtl/sorted_drain.sv
// Batch sorter: collects up to DEPTH words, then replays them largest-first.
// Storage is unsorted; each drain beat selects the current maximum combinationally.
module sorted_drain #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      used_q, used_d;
  logic [CntW-1:0]       count_q, count_d;

  logic [IdxW-1:0]       free_idx;
  logic [IdxW-1:0]       max_idx;
  logic [DATA_WIDTH-1:0] max_val;
  logic                  max_found;

  // Lowest-index unused slot: scan downward so the last hit is the lowest.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!used_q[i]) free_idx = IdxW'(i);
    end
  end

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    max_idx   = '0;
    max_val   = '0;
    max_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (used_q[i] && (!max_found || data_q[i] > max_val)) begin
        max_idx   = IdxW'(i);
        max_val   = data_q[i];
        max_found = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == StFill);
    out_valid = (state_q == StDrain);
    dout      = out_valid ? max_val : '0;
    out_last  = out_valid && (count_q == CntW'(1));
    count     = count_q;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    used_d  = used_q;
    count_d = count_q;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          data_d[free_idx] = din;
          used_d[free_idx] = 1'b1;
          count_d          = count_q + CntW'(1);
          if (in_last || count_q == CntW'(DEPTH - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_ready) begin
          used_d[max_idx] = 1'b0;
          count_d         = count_q - CntW'(1);
          if (count_q == CntW'(1)) state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StFill;
      used_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_sorted_drain.sv
// Scoreboard bench for sorted_drain: each completed batch is sorted by the bench
// and queued as the expected descending output sequence.
module tb_sorted_drain;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;
  logic          out_last;
  logic [CW-1:0] count;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] batch_q [$];
  logic [DW-1:0] exp_q   [$];

  sorted_drain #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_last  (out_last),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Move the completed batch into the expected queue, largest first.
  task automatic flush_batch();
    while (batch_q.size() > 0) begin
      int best = 0;
      for (int i = 1; i < batch_q.size(); i++)
        if (batch_q[i] > batch_q[best]) best = i;
      exp_q.push_back(batch_q[best]);
      batch_q.delete(best);
    end
  endtask

  task automatic push(input logic [DW-1:0] w, input logic last);
    in_valid = 1'b1;
    din      = w;
    in_last  = last;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: in_ready=%b required 1 (word %0h)", in_ready, w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    din      = '0;
    batch_q.push_back(w);
    if (last || batch_q.size() == DEPTH) flush_batch();
  endtask

  // Pops n beats with out_ready high, checking every output against the scoreboard.
  task automatic drain_beats(input int n);
    out_ready = 1'b1;
    for (int b = 0; b < n; b++) begin
      logic [DW-1:0] exp_w;
      logic          exp_l;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_underrun: scoreboard empty at beat %0d", b);
        break;
      end
      exp_l = (exp_q.size() == 1);
      checks++;
      if (count !== CW'(exp_q.size())) begin
        errors++;
        $display("FAIL drain_count: count=%0d required %0d", count, exp_q.size());
      end
      exp_w = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_valid: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
      end
      checks++;
      if (dout !== exp_w) begin
        errors++;
        $display("FAIL drain_data: dout=%0h required %0h", dout, exp_w);
      end
      checks++;
      if (out_last !== exp_l) begin
        errors++;
        $display("FAIL drain_last: out_last=%b required %b", out_last, exp_l);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_fill_idle(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || dout !== '0
        || count !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b dout=%0h count=%0d required 1/0/0/0/0",
               tag, in_ready, out_valid, out_last, dout, count);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    din       = '0;
    out_ready = 1'b0;
    #12;
    check_fill_idle("reset_state");
    resetn = 1'b1;
    @(posedge clk); #1;
    check_fill_idle("after_reset");
  endtask

  task automatic test_basic();
    push(32'd5, 1'b0);
    push(32'd9, 1'b0);
    push(32'd2, 1'b0);
    push(32'd7, 1'b1);
    drain_beats(4);
    check_fill_idle("basic_refill");
  endtask

  task automatic test_auto_full();
    for (int i = 1; i <= DEPTH; i++) push(DW'(i), 1'b0);
    checks++;
    if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL auto_full: in_ready=%b count=%0d required 0/%0d", in_ready, count, DEPTH);
    end
    drain_beats(DEPTH);
    check_fill_idle("auto_full_refill");
  endtask

  task automatic test_dups_extremes();
    push(32'd3, 1'b0);
    push(32'hFFFF_FFFF, 1'b0);
    push(32'd3, 1'b0);
    push(32'd0, 1'b1);
    drain_beats(4);
    check_fill_idle("dups_refill");
  endtask

  task automatic test_backpressure();
    push(32'd4, 1'b0);
    push(32'd6, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || dout !== 32'd6 || out_last !== 1'b0 || count !== CW'(2)) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b dout=%0h last=%b count=%0d required 1/6/0/2",
                 out_valid, dout, out_last, count);
      end
      @(posedge clk); #1;
    end
    drain_beats(2);
    check_fill_idle("backpressure_refill");
  endtask

  task automatic test_single();
    push(32'd42, 1'b1);
    drain_beats(1);
    check_fill_idle("single_refill");
  endtask

  task automatic test_reset_mid_drain();
    push(32'd10, 1'b0);
    push(32'd20, 1'b0);
    push(32'd30, 1'b1);
    drain_beats(2);
    resetn = 1'b0;
    #1;
    check_fill_idle("reset_mid_drain");
    exp_q.delete();
    batch_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    push(32'd1, 1'b1);
    drain_beats(1);
    check_fill_idle("post_reset_batch");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto_full();
    test_dups_extremes();
    test_backpressure();
    test_single();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
